// File: rtl/viterbi_ctrl.sv
// Frame-level sequencer for the K=3, rate-1/2 Viterbi decoder datapath.
// Issues path-metric init, one ACS/survivor-write step per accepted symbol
// pair, then a full-frame traceback from the last column down to column 0.
// Symbol data never passes through here; only enables and addresses do.
module viterbi_ctrl #(
  parameter int FRAME_LEN = 16,
  parameter int ADDR_W    = 4
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              start_i,
  input  logic              abort_i,
  input  logic              sym_valid_i,
  output logic              sym_ready_o,
  output logic              pm_init_o,
  output logic              acs_en_o,
  output logic              sm_wr_en_o,
  output logic [ADDR_W-1:0] sm_wr_addr_o,
  output logic              tb_en_o,
  output logic              tb_first_o,
  output logic [ADDR_W-1:0] tb_rd_addr_o,
  output logic              busy_o,
  output logic              done_o
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_INIT  = 3'd1,
    S_ACS   = 3'd2,
    S_TRACE = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_COL = ADDR_W'(FRAME_LEN - 1);

  state_t            state;
  logic [ADDR_W-1:0] sym_cnt;
  // Traceback counter doubles as the read column; it is zero outside TRACE.
  logic [ADDR_W-1:0] tb_cnt;
  logic              ready_q;
  logic              pm_init_q;
  logic              tb_en_q;
  logic              tb_first_q;
  logic              busy_q;
  logic              done_q;
  logic              accept;

  // A pair is taken only when the controller is ready and no abort is pending.
  assign accept = sym_valid_i & ready_q & ~abort_i;

  // Sequencer: state, counters and all registered outputs advance together.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state      <= S_IDLE;
      sym_cnt    <= '0;
      tb_cnt     <= '0;
      ready_q    <= 1'b0;
      pm_init_q  <= 1'b0;
      tb_en_q    <= 1'b0;
      tb_first_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else if (abort_i) begin
      // Abort overrides every transition, including a start in IDLE.
      state      <= S_IDLE;
      sym_cnt    <= '0;
      tb_cnt     <= '0;
      ready_q    <= 1'b0;
      pm_init_q  <= 1'b0;
      tb_en_q    <= 1'b0;
      tb_first_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start_i) begin
            state     <= S_INIT;
            pm_init_q <= 1'b1;
            busy_q    <= 1'b1;
          end
        end
        S_INIT: begin
          state     <= S_ACS;
          pm_init_q <= 1'b0;
          ready_q   <= 1'b1;
        end
        S_ACS: begin
          if (accept) begin
            if (sym_cnt == LAST_COL) begin
              // Last column written: hand over to traceback from the top column.
              state      <= S_TRACE;
              sym_cnt    <= '0;
              ready_q    <= 1'b0;
              tb_en_q    <= 1'b1;
              tb_first_q <= 1'b1;
              tb_cnt     <= LAST_COL;
            end else begin
              sym_cnt <= sym_cnt + 1'b1;
            end
          end
        end
        S_TRACE: begin
          tb_first_q <= 1'b0;
          if (tb_cnt == '0) begin
            state   <= S_DONE;
            tb_en_q <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            tb_cnt <= tb_cnt - 1'b1;
          end
        end
        S_DONE: begin
          state  <= S_IDLE;
          done_q <= 1'b0;
          busy_q <= 1'b0;
        end
        default: begin
          state      <= S_IDLE;
          sym_cnt    <= '0;
          tb_cnt     <= '0;
          ready_q    <= 1'b0;
          pm_init_q  <= 1'b0;
          tb_en_q    <= 1'b0;
          tb_first_q <= 1'b0;
          busy_q     <= 1'b0;
          done_q     <= 1'b0;
        end
      endcase
    end
  end

  assign sym_ready_o  = ready_q;
  assign pm_init_o    = pm_init_q;
  assign acs_en_o     = accept;
  assign sm_wr_en_o   = accept;
  assign sm_wr_addr_o = accept ? sym_cnt : '0;
  assign tb_en_o      = tb_en_q & ~abort_i;
  assign tb_first_o   = tb_first_q;
  assign tb_rd_addr_o = tb_cnt;
  assign busy_o       = busy_q;
  assign done_o       = done_q;

endmodule

// File: tb/tb_viterbi_ctrl.sv
// Bench for viterbi_ctrl: two instances (FRAME_LEN 16 and 5) share stimulus.
// Expected outputs come from a frame-position model: position -1 is idle,
// 0 is init, 1..L waits for pair (pos-1), L+1..2L is traceback, 2L+1 is done.
module tb_viterbi_ctrl;

  typedef struct packed {
    logic       ready;
    logic       pm_init;
    logic       acs_en;
    logic       wr_en;
    logic [3:0] wr_addr;
    logic       tb_en;
    logic       tb_first;
    logic [3:0] rd_addr;
    logic       busy;
    logic       done;
  } out_t;

  typedef struct {
    logic st;
    logic ab;
    logic v;
    out_t exp;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic abort = 1'b0;
  logic valid = 1'b0;

  always #5 clk = ~clk;

  logic       a_ready, a_pm, a_acs, a_wr, a_te, a_tf, a_busy, a_done;
  logic [3:0] a_wa, a_ra;
  logic       b_ready, b_pm, b_acs, b_wr, b_te, b_tf, b_busy, b_done;
  logic [2:0] b_wa, b_ra;

  viterbi_ctrl #(.FRAME_LEN(16), .ADDR_W(4)) dut_a (
    .clk_i(clk), .rst_n_i(rst_n), .start_i(start), .abort_i(abort),
    .sym_valid_i(valid), .sym_ready_o(a_ready), .pm_init_o(a_pm),
    .acs_en_o(a_acs), .sm_wr_en_o(a_wr), .sm_wr_addr_o(a_wa),
    .tb_en_o(a_te), .tb_first_o(a_tf), .tb_rd_addr_o(a_ra),
    .busy_o(a_busy), .done_o(a_done)
  );

  viterbi_ctrl #(.FRAME_LEN(5), .ADDR_W(3)) dut_b (
    .clk_i(clk), .rst_n_i(rst_n), .start_i(start), .abort_i(abort),
    .sym_valid_i(valid), .sym_ready_o(b_ready), .pm_init_o(b_pm),
    .acs_en_o(b_acs), .sm_wr_en_o(b_wr), .sm_wr_addr_o(b_wa),
    .tb_en_o(b_te), .tb_first_o(b_tf), .tb_rd_addr_o(b_ra),
    .busy_o(b_busy), .done_o(b_done)
  );

  out_t a_o, b_o;
  assign a_o = {a_ready, a_pm, a_acs, a_wr, a_wa, a_te, a_tf, a_ra, a_busy, a_done};
  assign b_o = {b_ready, b_pm, b_acs, b_wr, 1'b0, b_wa, b_te, b_tf, 1'b0, b_ra, b_busy, b_done};

  int   vectors = 0;
  int   fails = 0;
  int   pos_a = -1;
  int   pos_b = -1;
  logic done_a, done_b;
  out_t b_snap;

  function automatic out_t mk(logic rdy, logic pm, logic acs, int wa, logic te,
                              logic tf, int ra, logic bz, logic dn);
    out_t o;
    o.ready    = rdy;
    o.pm_init  = pm;
    o.acs_en   = acs;
    o.wr_en    = acs;
    o.wr_addr  = 4'(wa);
    o.tb_en    = te;
    o.tb_first = tf;
    o.rd_addr  = 4'(ra);
    o.busy     = bz;
    o.done     = dn;
    return o;
  endfunction

  function automatic out_t model(int p, int fl, logic v, logic ab);
    logic in_acs;
    logic in_tb;
    logic acc;
    in_acs = (p >= 1) && (p <= fl);
    in_tb  = (p >= fl + 1) && (p <= 2 * fl);
    acc    = in_acs && v && !ab;
    return mk(in_acs, p == 0, acc, acc ? p - 1 : 0, in_tb && !ab, p == fl + 1,
              in_tb ? 2 * fl - p : 0, p >= 0, p == 2 * fl + 1);
  endfunction

  function automatic int nxt(int p, int fl, logic st, logic v, logic ab);
    if (ab) return -1;
    if (p < 0) return st ? 0 : -1;
    if (p >= 1 && p <= fl && !v) return p;
    if (p == 2 * fl + 1) return -1;
    return p + 1;
  endfunction

  task automatic chk(input string name, input out_t got, input out_t exp);
    vectors++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic chk_int(input string name, input int got, input int exp);
    vectors++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  // Called at a falling edge: drive, check both instances, clock, advance models.
  task automatic cycle(input logic st, input logic ab, input logic v, input string tag);
    start = st;
    abort = ab;
    valid = v;
    #1;
    chk({tag, "/L16"}, a_o, model(pos_a, 16, v, ab));
    chk({tag, "/L5"}, b_o, model(pos_b, 5, v, ab));
    done_a = a_o.done;
    done_b = b_o.done;
    b_snap = b_o;
    @(posedge clk);
    pos_a = nxt(pos_a, 16, st, v, ab);
    pos_b = nxt(pos_b, 5, st, v, ab);
    @(negedge clk);
  endtask

  // One frame from idle; cycle 1 carries the start pulse. Reports done cycle numbers.
  task automatic run_frame(input bit stalls, input bit extra_starts,
                           input int exp_a, input int exp_b, input string tag);
    int  first_a;
    int  first_b;
    int  cnt_a;
    int  cnt_b;
    logic v;
    logic st;
    first_a = 0;
    first_b = 0;
    cnt_a   = 0;
    cnt_b   = 0;
    for (int n = 1; n <= 80; n++) begin
      v  = !(stalls && ((n >= 7 && n <= 9) || (n >= 16 && n <= 18)));
      st = (n == 1) || (extra_starts && (n == 8 || n == 13));
      cycle(st, 1'b0, v, tag);
      if (done_a) begin
        cnt_a++;
        if (first_a == 0) first_a = n;
      end
      if (done_b) begin
        cnt_b++;
        if (first_b == 0) first_b = n;
      end
      if (first_a > 0 && first_b > 0 && n >= first_a + 2 && n >= first_b + 2) break;
    end
    chk_int({tag, "_lat16"}, first_a, exp_a);
    chk_int({tag, "_lat5"}, first_b, exp_b);
    chk_int({tag, "_done_cnt16"}, cnt_a, 1);
    chk_int({tag, "_done_cnt5"}, cnt_b, 1);
  endtask

  vec_t tbl[17];

  initial begin
    int k;
    // Hand-derived sequence for the FRAME_LEN=5 instance: one stall after
    // pair 0, ignored starts in ACS and DONE, abort+start together in IDLE.
    tbl[0]  = '{1'b1, 1'b0, 1'b0, mk(0, 0, 0, 0, 0, 0, 0, 0, 0)};
    tbl[1]  = '{1'b0, 1'b0, 1'b1, mk(0, 1, 0, 0, 0, 0, 0, 1, 0)};
    tbl[2]  = '{1'b0, 1'b0, 1'b1, mk(1, 0, 1, 0, 0, 0, 0, 1, 0)};
    tbl[3]  = '{1'b0, 1'b0, 1'b0, mk(1, 0, 0, 0, 0, 0, 0, 1, 0)};
    tbl[4]  = '{1'b0, 1'b0, 1'b1, mk(1, 0, 1, 1, 0, 0, 0, 1, 0)};
    tbl[5]  = '{1'b1, 1'b0, 1'b1, mk(1, 0, 1, 2, 0, 0, 0, 1, 0)};
    tbl[6]  = '{1'b0, 1'b0, 1'b1, mk(1, 0, 1, 3, 0, 0, 0, 1, 0)};
    tbl[7]  = '{1'b0, 1'b0, 1'b1, mk(1, 0, 1, 4, 0, 0, 0, 1, 0)};
    tbl[8]  = '{1'b0, 1'b0, 1'b0, mk(0, 0, 0, 0, 1, 1, 4, 1, 0)};
    tbl[9]  = '{1'b0, 1'b0, 1'b0, mk(0, 0, 0, 0, 1, 0, 3, 1, 0)};
    tbl[10] = '{1'b0, 1'b0, 1'b0, mk(0, 0, 0, 0, 1, 0, 2, 1, 0)};
    tbl[11] = '{1'b0, 1'b0, 1'b0, mk(0, 0, 0, 0, 1, 0, 1, 1, 0)};
    tbl[12] = '{1'b0, 1'b0, 1'b0, mk(0, 0, 0, 0, 1, 0, 0, 1, 0)};
    tbl[13] = '{1'b1, 1'b0, 1'b0, mk(0, 0, 0, 0, 0, 0, 0, 1, 1)};
    tbl[14] = '{1'b0, 1'b0, 1'b0, mk(0, 0, 0, 0, 0, 0, 0, 0, 0)};
    tbl[15] = '{1'b1, 1'b1, 1'b0, mk(0, 0, 0, 0, 0, 0, 0, 0, 0)};
    tbl[16] = '{1'b0, 1'b0, 1'b0, mk(0, 0, 0, 0, 0, 0, 0, 0, 0)};

    // Power-on reset
    rst_n = 1'b0;
    valid = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    chk("por/L16", a_o, mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
    chk("por/L5", b_o, mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
    @(negedge clk);
    rst_n = 1'b1;
    pos_a = -1;
    pos_b = -1;
    cycle(1'b0, 1'b0, 1'b0, "idle");

    // Table-driven vectors
    for (int i = 0; i < 17; i++) begin
      cycle(tbl[i].st, tbl[i].ab, tbl[i].v, "tbl_model");
      chk($sformatf("tbl[%0d]", i), b_snap, tbl[i].exp);
    end
    cycle(1'b0, 1'b1, 1'b0, "abort_flush");
    cycle(1'b0, 1'b0, 1'b0, "idle2");

    // Asynchronous reset in the middle of ACS with sym_cnt=5
    cycle(1'b1, 1'b0, 1'b0, "rst_pre");
    cycle(1'b0, 1'b0, 1'b1, "rst_pre");
    repeat (5) cycle(1'b0, 1'b0, 1'b1, "rst_pre");
    chk_int("rst_wr_addr5", int'(a_o.wr_addr), 5);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst/L16", a_o, mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
    chk("async_rst/L5", b_o, mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
    @(negedge clk);
    rst_n = 1'b1;
    pos_a = -1;
    pos_b = -1;
    cycle(1'b0, 1'b0, 1'b1, "post_rst");

    // Clean frame with ignored starts, then a stalled frame
    run_frame(1'b0, 1'b1, 35, 13, "clean");
    run_frame(1'b1, 1'b0, 41, 16, "stall");

    // Abort during traceback at read column 7
    k = 0;
    while (!(a_o.tb_en && a_o.rd_addr == 4'd7) && k < 60) begin
      cycle(k == 0, 1'b0, 1'b1, "pre_abort");
      k++;
    end
    if (k >= 60) begin
      fails++;
      $display("FAIL abort_wait: got timeout expected rd_addr 7");
    end
    cycle(1'b0, 1'b1, 1'b1, "abort");
    chk_int("abort_tb_en", int'(a_o.tb_en), 0);
    cycle(1'b0, 1'b0, 1'b1, "after_abort");
    chk_int("after_abort_busy", int'(a_o.busy), 0);
    run_frame(1'b0, 1'b0, 35, 13, "reframe");

    // Randomized traffic against the position model
    for (int i = 0; i < 3000; i++) begin
      cycle($urandom_range(0, 9) == 0, $urandom_range(0, 49) == 0,
            $urandom_range(0, 3) != 0, "rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
